// File: rtl/bcd_tod_pkg.sv
// Shared constants, BCD helpers and alarm state type for the BCD time-of-day clock.
// All time fields are packed two-digit BCD.
package bcd_tod_pkg;

   localparam logic [7:0] BCD_MAX_59 = 8'h59;
   localparam logic [7:0] BCD_MAX_23 = 8'h23;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RING = 1'b1
   } alarm_state_t;

   // Two-digit BCD increment that wraps to 00 after max.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      logic [7:0] r;
      if (v == max) begin
         r = 8'h00;
      end else if (v[3:0] == 4'h9) begin
         r = {v[7:4] + 4'h1, 4'h0};
      end else begin
         r = {v[7:4], v[3:0] + 4'h1};
      end
      return r;
   endfunction

   // Returns {pm, display_hour} for an internal 00-23 BCD hour.
   function automatic logic [8:0] to_12h(input logic [7:0] h);
      logic [7:0] b;
      logic [8:0] r;
      b = ({4'h0, h[7:4]} * 8'd10) + {4'h0, h[3:0]};
      if (b == 8'd0) begin
         r = {1'b0, 8'h12};
      end else if (b < 8'd12) begin
         r = {1'b0, h};
      end else if (b == 8'd12) begin
         r = {1'b1, 8'h12};
      end else begin
         b = b - 8'd12;
         r = {1'b1, 4'(b / 8'd10), 4'(b % 8'd10)};
      end
      return r;
   endfunction

   function automatic logic bcd_hhmm_ok(input logic [7:0] hr, input logic [7:0] mn);
      return (hr[3:0] <= 4'h9) && (mn[3:0] <= 4'h9) &&
             (hr <= BCD_MAX_23) && (mn <= BCD_MAX_59);
   endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter wrapping at MAX; carry flags an increment taken from MAX.
module bcd2_counter
   import bcd_tod_pkg::*;
#(
   parameter logic [7:0] MAX = BCD_MAX_59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] value,
   output logic       carry
);

   logic [7:0] value_r;

   // Count register; clear has priority over increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_r <= 8'h00;
      end else if (clr) begin
         value_r <= 8'h00;
      end else if (inc) begin
         value_r <= bcd_inc(value_r, MAX);
      end else begin
         value_r <= value_r;
      end
   end

   assign value = value_r;
   assign carry = inc && (value_r == MAX);

endmodule

// File: rtl/bcd_tod_clock.sv
// BCD time-of-day core: second prescaler, sec/min/hour counters, 12/24h display,
// set mode and a single-entry alarm with timeout.
module bcd_tod_clock
   import bcd_tod_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 100_000_000,
   parameter int unsigned ALARM_LEN = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_12h,
   input  logic       set_en,
   input  logic       inc_hr,
   input  logic       inc_min,
   input  logic       clr_sec,
   input  logic       alarm_ld,
   input  logic [7:0] alarm_hr,
   input  logic [7:0] alarm_min,
   input  logic       alarm_en,
   input  logic       alarm_ack,
   output logic [7:0] hour,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic       pm,
   output logic       sec_pulse,
   output logic       alarm,
   output logic       alarm_err
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = $clog2(ALARM_LEN + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DUR_LAST   = DW'(ALARM_LEN - 1);

   logic [PW-1:0] presc_r;
   logic [DW-1:0] dur_r;
   logic [7:0]    alm_hr_r, alm_min_r;
   logic          sec_pulse_r, alarm_err_r;
   alarm_state_t  state_r, state_nxt_s;

   logic          tick_s, sec_adv_s, min_inc_s, hr_inc_s, match_s;
   logic          sec_carry_s, min_carry_s, hr_carry_unused_s;
   logic [7:0]    sec_val_s, min_val_s, hr_val_s, nxt_min_s, nxt_hr_s;
   logic [8:0]    disp12_s;

   // Prescaler: frozen at 0 in set mode, restarted by clr_sec
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_r <= '0;
      end else if (set_en || clr_sec || tick_s) begin
         presc_r <= '0;
      end else begin
         presc_r <= presc_r + PW'(1'b1);
      end
   end

   // Tick and edit routing; minute carry only propagates outside set mode
   always_comb begin
      tick_s    = !set_en && (presc_r == PRESC_LAST);
      sec_adv_s = tick_s && !clr_sec;
      min_inc_s = sec_carry_s || (set_en && inc_min);
      hr_inc_s  = (min_carry_s && !set_en) || (set_en && inc_hr);
   end

   bcd2_counter #(.MAX(BCD_MAX_59)) u_sec (
      .clk(clk), .rst(rst), .inc(sec_adv_s), .clr(clr_sec),
      .value(sec_val_s), .carry(sec_carry_s));

   bcd2_counter #(.MAX(BCD_MAX_59)) u_min (
      .clk(clk), .rst(rst), .inc(min_inc_s), .clr(1'b0),
      .value(min_val_s), .carry(min_carry_s));

   bcd2_counter #(.MAX(BCD_MAX_23)) u_hr (
      .clk(clk), .rst(rst), .inc(hr_inc_s), .clr(1'b0),
      .value(hr_val_s), .carry(hr_carry_unused_s));

   // Match is evaluated on the hour:min the seconds rollover is about to produce
   always_comb begin
      nxt_min_s = bcd_inc(min_val_s, BCD_MAX_59);
      nxt_hr_s  = (min_val_s == BCD_MAX_59) ? bcd_inc(hr_val_s, BCD_MAX_23) : hr_val_s;
      match_s   = alarm_en && sec_carry_s &&
                  (nxt_hr_s == alm_hr_r) && (nxt_min_s == alm_min_r);
   end

   // Alarm registers, pulse outputs and ring-duration counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alm_hr_r    <= 8'h00;
         alm_min_r   <= 8'h00;
         alarm_err_r <= 1'b0;
         sec_pulse_r <= 1'b0;
         dur_r       <= '0;
      end else begin
         if (alarm_ld && bcd_hhmm_ok(alarm_hr, alarm_min)) begin
            alm_hr_r  <= alarm_hr;
            alm_min_r <= alarm_min;
         end
         alarm_err_r <= alarm_ld && !bcd_hhmm_ok(alarm_hr, alarm_min);
         sec_pulse_r <= tick_s;
         if (match_s || (state_r == IDLE)) begin
            dur_r <= '0;
         end else if (tick_s) begin
            dur_r <= dur_r + DW'(1'b1);
         end
      end
   end

   // Alarm state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Alarm next state; a fresh match outranks ack and restarts the duration
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (match_s) state_nxt_s = RING;
            else         state_nxt_s = IDLE;
         end
         RING: begin
            if (match_s)
               state_nxt_s = RING;
            else if (alarm_ack || !alarm_en || (tick_s && (dur_r == DUR_LAST)))
               state_nxt_s = IDLE;
            else
               state_nxt_s = RING;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output decode including 12-hour display mapping
   always_comb begin
      disp12_s  = to_12h(hr_val_s);
      alarm     = (state_r == RING);
      min       = min_val_s;
      sec       = sec_val_s;
      sec_pulse = sec_pulse_r;
      alarm_err = alarm_err_r;
      if (mode_12h) begin
         pm   = disp12_s[8];
         hour = disp12_s[7:0];
      end else begin
         pm   = 1'b0;
         hour = hr_val_s;
      end
   end

endmodule
